// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encoding and the instruction-memory depth
// default shared with the fetch stage.
package imem_loader_pkg;

  localparam int IMEM_SIZE_DEFAULT = 256;
  localparam int LEN_W_DEFAULT     = 16;

  typedef enum logic [2:0] {
    LD_LEN_HI,
    LD_LEN_LO,
    LD_DATA,
    LD_CKSUM,
    LD_RUN,
    LD_ERROR
  } ld_state_e;

endpackage

// File: rtl/imem_word_pack.sv
// imem_word_pack: assembles four stream bytes, MSB first, into a 32-bit word and
// flags the byte that completes it.
module imem_word_pack
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word_out
);

  logic [23:0] asm_q, asm_d;
  logic [1:0]  idx_q, idx_d;

  // The completing byte is merged combinationally so the caller can register
  // the whole word on the same edge that accepts it.
  always_comb begin
    asm_d      = asm_q;
    idx_d      = idx_q;
    word_ready = byte_en && (idx_q == 2'd3);
    word_out   = {asm_q, byte_in};
    if (clr) begin
      asm_d = '0;
      idx_d = '0;
    end else if (byte_en) begin
      asm_d = {asm_q[15:0], byte_in};
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
      idx_q <= '0;
    end else begin
      asm_q <= asm_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader that fills instruction memory and holds
// the core in reset until the frame is complete. IMEM_LOADER_CKSUM_EN adds a trailing XOR check byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_SIZE = IMEM_SIZE_DEFAULT,
  parameter int LEN_W     = LEN_W_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        RELOAD,
  output logic        WE,
  output logic [31:0] W_Addr,
  output logic [31:0] W_Ins,
  output logic        CORE_RST,
  output logic        DONE,
  output logic        ERR
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(IMEM_SIZE);
  localparam logic [LEN_W:0] IDX_ONE = (LEN_W+1)'(1);
`ifdef IMEM_LOADER_CKSUM_EN
  localparam ld_state_e LD_AFTER_DATA = LD_CKSUM;
`else
  localparam ld_state_e LD_AFTER_DATA = LD_RUN;
`endif

  ld_state_e        state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   word_idx_q, word_idx_d;
  logic             we_q, we_d;
  logic [31:0]      w_addr_q, w_addr_d;
  logic [31:0]      w_ins_q, w_ins_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]       cksum_q, cksum_d;
`endif

  logic             xfer;
  logic             pack_en;
  logic             pack_clr;
  logic             word_ready;
  logic [31:0]      word;
  logic [LEN_W-1:0] len_rx;

  assign IN_READY = (state_q == LD_LEN_HI) || (state_q == LD_LEN_LO) ||
                    (state_q == LD_DATA)   || (state_q == LD_CKSUM);
  assign xfer     = IN_VALID && IN_READY;
  assign pack_en  = xfer && (state_q == LD_DATA);
  assign len_rx   = LEN_W'({len_hi_q, IN_DATA});

  imem_word_pack u_pack (
    .clk        (CLK),
    .rst        (RST),
    .clr        (pack_clr),
    .byte_en    (pack_en),
    .byte_in    (IN_DATA),
    .word_ready (word_ready),
    .word_out   (word)
  );

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    w_addr_d   = w_addr_q;
    w_ins_d    = w_ins_q;
    pack_clr   = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    cksum_d = cksum_q;
    if (xfer && (state_q != LD_CKSUM)) cksum_d = cksum_q ^ IN_DATA;
`endif
    case (state_q)
      LD_LEN_HI: if (xfer) begin
        len_hi_d = IN_DATA;
        state_d  = LD_LEN_LO;
      end
      LD_LEN_LO: if (xfer) begin
        len_d = len_rx;
        if (len_rx == '0)                  state_d = LD_AFTER_DATA;
        else if ({1'b0, len_rx} > MAX_LEN) state_d = LD_ERROR;
        else                               state_d = LD_DATA;
      end
      LD_DATA: if (word_ready) begin
        we_d       = 1'b1;
        w_ins_d    = word;
        w_addr_d   = 32'({word_idx_q, 2'b00});
        word_idx_d = word_idx_q + IDX_ONE;
        // Leaving DATA on the same edge as the final WE keeps the core in
        // reset until that word is already presented to memory.
        if (word_idx_q + IDX_ONE == {1'b0, len_q}) state_d = LD_AFTER_DATA;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      LD_CKSUM: if (xfer) begin
        state_d = (IN_DATA == cksum_q) ? LD_RUN : LD_ERROR;
      end
`endif
      LD_RUN, LD_ERROR: if (RELOAD) begin
        state_d    = LD_LEN_HI;
        len_hi_d   = '0;
        len_d      = '0;
        word_idx_d = '0;
        pack_clr   = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum_d    = '0;
`endif
      end
      default: state_d = LD_ERROR;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= LD_LEN_HI;
      len_hi_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      we_q       <= 1'b0;
      w_addr_q   <= '0;
      w_ins_q    <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      we_q       <= we_d;
      w_addr_q   <= w_addr_d;
      w_ins_q    <= w_ins_d;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign WE       = we_q;
  assign W_Addr   = w_addr_q;
  assign W_Ins    = w_ins_q;
  assign CORE_RST = (state_q != LD_RUN);
  assign DONE     = (state_q == LD_RUN);
  assign ERR      = (state_q == LD_ERROR);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Host-side program loader that writes a MIPS program into instruction memory over a byte-serial valid/ready stream.
- Assembles big-endian 32-bit instruction words and drives the instruction-memory write port (WE, W_Addr, W_Ins).
- Holds the core in reset (CORE_RST) until the load completes, then releases it so fetch starts at PC=0.

Parameters:
- IMEM_SIZE, 256, instruction memory depth in words; a load longer than this is rejected.
- LEN_W, 16, width of the word-count header field.

Ports:
- CLK  input  1  system clock, all state on posedge
- RST  input  1  asynchronous, active-high reset
- IN_DATA  input  8  stream byte
- IN_VALID  input  1  IN_DATA valid
- IN_READY  output  1  loader accepts byte; transfer occurs when IN_VALID & IN_READY at posedge
- RELOAD  input  1  one-cycle request to start a new load (honoured in RUN/ERROR only)
- WE  output  1  instruction-memory write strobe, one cycle per word
- W_Addr  output  32  byte address of the word being written, always word-aligned
- W_Ins  output  32  instruction word being written
- CORE_RST  output  1  holds the core in reset while high
- DONE  output  1  high in RUN
- ERR  output  1  high in ERROR, sticky

Behaviour:
- Reset values, asynchronous on RST:
  - state=LEN_HI; CORE_RST=1; WE=0; W_Addr=0; W_Ins=0.
  - DONE=0; ERR=0; word count=0; byte index=0.
- Frame format: LEN[15:8], LEN[7:0], then 4*LEN bytes, each word MSB first. With CKSUM_EN, one checksum byte follows the data.
- States:
  - LEN_HI: on a byte transfer, latch the high length byte, then go to LEN_LO.
  - LEN_LO: on a byte transfer, latch the low length byte. If LEN=0, go to RUN (or CKSUM when CKSUM_EN). If LEN>IMEM_SIZE, go to ERROR. Otherwise go to DATA.
  - DATA: shift each accepted byte into the assembly register.
    - On the 4th byte: next cycle WE=1, W_Ins=assembled word, W_Addr=word_idx<<2. Then word_idx+1 and byte index back to 0.
    - After word LEN-1 is written, go to RUN (or CKSUM).
  - CKSUM: one byte; compare with the running check value. Match goes to RUN, mismatch to ERROR.
  - RUN: CORE_RST=0, DONE=1, IN_READY=0; bytes are ignored.
  - ERROR: CORE_RST=1, ERR=1, IN_READY=0; remains until RST or RELOAD.
- IN_READY=1 exactly in LEN_HI, LEN_LO, DATA, CKSUM. The loader never stalls inside these states, so throughput is 1 byte/cycle.
- Write latency: WE is registered and is high for exactly the cycle after the 4th byte handshake. At most one WE every 4 cycles.
- CORE_RST deasserts on the first cycle of RUN. The final WE has already occurred one cycle before RUN entry, or in the same cycle as the state update, so the last word is in memory before the core leaves reset.
- RELOAD in RUN or ERROR:
  - Next state LEN_HI; CORE_RST=1 the same edge.
  - DONE/ERR cleared; counters and check value cleared.
- RELOAD in any loading state is ignored.
- RELOAD and a byte handshake never coincide, because IN_READY=0 in RUN/ERROR.
- RST mid-word discards the partial word; no WE is issued.
- Gaps in IN_VALID are allowed anywhere; state is held.
- word_idx is LEN_W+1 bits wide, so LEN=IMEM_SIZE writes the last address IMEM_SIZE*4-4 without wrap.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- Defined:
  - Running XOR of all length and data bytes; CKSUM state present.
  - Frame must end with that XOR; mismatch goes to ERROR.
  - Memory words already written remain in memory, but the core stays in reset.
- Undefined:
  - No CKSUM state, no check register; the last data word (or LEN=0) goes directly to RUN.

Decomposition:
- Shared package/include (common_param.vh):
  - state encodings LD_LEN_HI, LD_LEN_LO, LD_DATA, LD_CKSUM, LD_RUN, LD_ERROR;
  - IMEM_SIZE default shared with the fetch stage.
- One natural sub-module, imem_word_pack: byte shift/assembly register with byte index and a word_ready pulse.
- The FSM, address counter and check value stay in imem_loader.

Test Plan:
- Stream 00 02 | 24 08 00 05 | 01 09 50 20: WE on 2 cycles; (W_Addr,W_Ins) = (0x0,0x24080005) then (0x4,0x01095020); CORE_RST falls, DONE=1; IN_READY=0 after.
- Stream 00 00: RUN immediately, no WE, DONE=1 (with CKSUM_EN: also send byte 00).
- LEN=0x0101 with IMEM_SIZE=256: ERROR after LEN_LO, ERR=1, CORE_RST=1, no WE. RELOAD then a valid 1-word frame gives DONE=1, ERR=0.
- Valid 1-word frame with random IN_VALID gaps: identical WE/address/data to gap-free run; each WE exactly 1 cycle.
- Assert RST after 2 data bytes of word 1: all outputs at reset values immediately (asynchronous). A fresh frame loads from W_Addr=0 correctly.
- CKSUM_EN: frame 00 01 12 34 56 78 + checksum 0x09 gives RUN; same frame with checksum 0x08 gives ERROR with word at 0x0 written, CORE_RST=1.
